// File: rtl/snowbro2_coin_cond.sv
// Coin/service input conditioning for snowbro2: 2-FF sync, tick-based debounce,
// and fixed-width coin pulses with an inter-coin gap, lockout and a one-deep coin queue.
module snowbro2_coin_cond #(
  parameter int unsigned TICK_DIV   = 48000,
  parameter int unsigned DEBOUNCE_T = 4,
  parameter int unsigned PULSE_T    = 100,
  parameter int unsigned GAP_T      = 50
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] COIN_INPUT,
  input  logic       SERVICE,
  input  logic [3:0] COIN_LOCK,
  output logic [3:0] COIN_OUT,
  output logic       SERVICE_OUT,
  output logic [3:0] COIN_EVT
);

  localparam int unsigned NCH     = 4;
  localparam int unsigned NLANE   = NCH + 1;
  localparam int unsigned PRESC_W = 16;
  localparam int unsigned CNT_W   = 8;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   DEB_LAST   = CNT_W'(DEBOUNCE_T - 1);
  localparam logic [CNT_W-1:0]   PULSE_LD   = CNT_W'(PULSE_T);
  localparam logic [CNT_W-1:0]   GAP_LD     = CNT_W'(GAP_T);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;

  logic [NLANE-1:0]   sync1_q, sync1_d;
  logic [NLANE-1:0]   sync2_q, sync2_d;
  logic [NLANE-1:0]   deb_q, deb_d;
  logic [CNT_W-1:0]   dcnt_q [NLANE];
  logic [CNT_W-1:0]   dcnt_d [NLANE];

  logic [NCH-1:0]     press_c;
  logic [NCH-1:0]     press_ok_c;

  state_e             state_q [NCH];
  state_e             state_d [NCH];
  logic [CNT_W-1:0]   cnt_q [NCH];
  logic [CNT_W-1:0]   cnt_d [NCH];
  logic [NCH-1:0]     pend_q, pend_d;
  logic [NCH-1:0]     coin_out_q, coin_out_d;
  logic [NCH-1:0]     evt_q, evt_d;

  // Prescaler: one-cycle registered tick on each wrap
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    tick_d  = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Synchroniser; lane NCH is the service switch
  always_comb begin
    sync1_d = {SERVICE, COIN_INPUT};
    sync2_d = sync1_q;
  end

  // Debounce: accept a new level once it has persisted for DEBOUNCE_T ticks
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NLANE; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        dcnt_d[i] = '0;
      end else if (tick_q) begin
        if (dcnt_q[i] == DEB_LAST) begin
          deb_d[i]  = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      for (int i = 0; i < NLANE; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      for (int i = 0; i < NLANE; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  // Press fires on the cycle the accepted level falls, so the FSM reacts on the same edge
  always_comb begin
    press_c    = deb_q[NCH-1:0] & ~deb_d[NCH-1:0];
    press_ok_c = press_c & ~COIN_LOCK;
  end

  // Per-channel coin FSM
  always_comb begin
    pend_d     = pend_q;
    evt_d      = '0;
    coin_out_d = '1;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (press_ok_c[i]) begin
            state_d[i] = ST_PULSE;
            cnt_d[i]   = PULSE_LD;
            evt_d[i]   = 1'b1;
          end
        end
        ST_PULSE: begin
          if (press_ok_c[i]) begin
            pend_d[i] = 1'b1;
          end
          if (tick_q) begin
            if (cnt_q[i] == CNT_ONE) begin
              state_d[i] = ST_GAP;
              cnt_d[i]   = GAP_LD;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
        end
        ST_GAP: begin
          if (press_ok_c[i]) begin
            pend_d[i] = 1'b1;
          end
          if (tick_q) begin
            if (cnt_q[i] == CNT_ONE) begin
              pend_d[i] = 1'b0;
              // A queued coin is re-qualified against the lock as the gap closes
              if ((pend_q[i] & ~COIN_LOCK[i]) | press_ok_c[i]) begin
                state_d[i] = ST_PULSE;
                cnt_d[i]   = PULSE_LD;
                evt_d[i]   = 1'b1;
              end else begin
                state_d[i] = ST_IDLE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          pend_d[i]  = 1'b0;
        end
      endcase
      coin_out_d[i] = (state_d[i] != ST_PULSE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q     <= '0;
      coin_out_q <= '1;
      evt_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      coin_out_q <= coin_out_d;
      evt_q      <= evt_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign COIN_OUT    = coin_out_q;
  assign COIN_EVT    = evt_q;
  assign SERVICE_OUT = deb_q[NCH];

endmodule
